// File: rtl/anim_pkg.sv
// Shared playback-mode and sequencer-state encodings for the animation frame sequencer.
package anim_pkg;

  typedef enum logic [1:0] {
    MODE_FWD      = 2'b00,
    MODE_REV      = 2'b01,
    MODE_PINGPONG = 2'b10,
    MODE_ONESHOT  = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_PAUSED = 2'b01,
    ST_DONE   = 2'b10
  } state_t;

endpackage

// File: rtl/anim_next_frame.sv
// Combinational advance rule: given the current frame, direction and mode, produce the
// frame/direction that one advance would yield, and flag a one-shot that has run out.
module anim_next_frame
  import anim_pkg::*;
#(
  parameter int NUM_FRAMES = 4,
  parameter int FRAME_W    = 2
) (
  input  logic [FRAME_W-1:0] n,
  input  logic               dir_rev,
  input  mode_t              mode,
  output logic [FRAME_W-1:0] n_next,
  output logic               dir_next,
  output logic               at_end
);

  localparam logic [FRAME_W-1:0] LAST = FRAME_W'(NUM_FRAMES - 1);
  localparam logic [FRAME_W-1:0] ONE  = FRAME_W'(1);

  // Direction only survives in ping-pong; every other mode drives it back to ascending.
  always_comb begin
    n_next   = n;
    dir_next = 1'b0;
    at_end   = 1'b0;
    if (NUM_FRAMES == 1) begin
      n_next = '0;
      at_end = (mode == MODE_ONESHOT);
    end else begin
      case (mode)
        MODE_FWD:      n_next = (n == LAST) ? '0 : n + ONE;
        MODE_REV:      n_next = (n == '0) ? LAST : n - ONE;
        MODE_PINGPONG: begin
          if (!dir_rev) begin
            if (n == LAST) begin
              dir_next = 1'b1;
              n_next   = n - ONE;
            end else begin
              n_next = n + ONE;
            end
          end else begin
            if (n == '0) begin
              n_next = n + ONE;
            end else begin
              dir_next = 1'b1;
              n_next   = n - ONE;
            end
          end
        end
        MODE_ONESHOT: begin
          if (n == LAST) at_end = 1'b1;
          else           n_next = n + ONE;
        end
        default: n_next = n;
      endcase
    end
  end

endmodule

// File: rtl/anim_frame_sequencer.sv
// Animation frame index generator: holds each frame for a programmable number of video
// frames and only ever updates frame_num on a frame tick (or restart), so no mid-scan tearing.
module anim_frame_sequencer
  import anim_pkg::*;
#(
  parameter int NUM_FRAMES = 4,
  parameter int FRAME_W    = 2,
  parameter int HOLD_W     = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic [HOLD_W-1:0]  hold_len,
  input  logic [1:0]         mode,
  input  logic               pause,
  input  logic               step,
  input  logic               restart,
  output logic [FRAME_W-1:0] frame_num,
  output logic               frame_change,
  output logic               done,
  output logic               dir_rev
);

  localparam logic [FRAME_W-1:0] LAST = FRAME_W'(NUM_FRAMES - 1);

  state_t              state, state_n;
  mode_t               mode_s;
  logic [HOLD_W-1:0]   hold_cnt, hold_d, hold_last;
  logic                step_pend, pend_d;
  logic                do_adv, hold_clr, hold_inc;
  logic [FRAME_W-1:0]  nf_n, n_d;
  logic                nf_dir, nf_end, dir_d, done_d;

  assign mode_s    = mode_t'(mode);
  assign hold_last = (hold_len == '0) ? '0 : hold_len - HOLD_W'(1);

  anim_next_frame #(
    .NUM_FRAMES (NUM_FRAMES),
    .FRAME_W    (FRAME_W)
  ) u_next (
    .n        (frame_num),
    .dir_rev  (dir_rev),
    .mode     (mode_s),
    .n_next   (nf_n),
    .dir_next (nf_dir),
    .at_end   (nf_end)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_RUN;
    else       state <= state_n;
  end

  // A tick that coincides with restart is dropped entirely.
  always_comb begin
    state_n  = state;
    do_adv   = 1'b0;
    hold_clr = 1'b0;
    hold_inc = 1'b0;
    if (!restart && frame_tick) begin
      case (state)
        ST_RUN: begin
          if (pause) begin
            state_n = ST_PAUSED;
          end else if (hold_cnt >= hold_last) begin
            hold_clr = 1'b1;
            do_adv   = 1'b1;
          end else begin
            hold_inc = 1'b1;
          end
        end
        ST_PAUSED: begin
          if (step_pend || step) begin
            do_adv   = 1'b1;
            hold_clr = 1'b1;
          end
          if (!pause) state_n = ST_RUN;
        end
        ST_DONE: begin
          if (mode_s != MODE_ONESHOT) begin
            state_n  = ST_RUN;
            hold_clr = 1'b1;
          end
        end
        default: state_n = ST_RUN;
      endcase
      if (do_adv && nf_end) state_n = ST_DONE;
    end
    if (restart) state_n = pause ? ST_PAUSED : ST_RUN;
  end

  always_comb begin
    n_d    = frame_num;
    dir_d  = dir_rev;
    done_d = done;
    hold_d = hold_cnt;
    pend_d = (state == ST_PAUSED && state_n == ST_PAUSED && !do_adv) ? (step_pend | step) : 1'b0;
    if (restart) begin
      n_d    = (mode_s == MODE_REV) ? LAST : '0;
      dir_d  = 1'b0;
      done_d = 1'b0;
      hold_d = '0;
      pend_d = 1'b0;
    end else begin
      if (hold_clr)      hold_d = '0;
      else if (hold_inc) hold_d = hold_cnt + HOLD_W'(1);
      if (do_adv) begin
        if (nf_end) begin
          done_d = 1'b1;
        end else begin
          n_d   = nf_n;
          dir_d = nf_dir;
        end
      end
      if (state == ST_DONE && state_n == ST_RUN) done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_num    <= '0;
      hold_cnt     <= '0;
      dir_rev      <= 1'b0;
      frame_change <= 1'b0;
      done         <= 1'b0;
      step_pend    <= 1'b0;
    end else begin
      frame_num    <= n_d;
      hold_cnt     <= hold_d;
      dir_rev      <= dir_d;
      frame_change <= (n_d != frame_num);
      done         <= done_d;
      step_pend    <= pend_d;
    end
  end

endmodule

// File: tb/tb_anim_frame_sequencer.sv
// Scoreboard bench for anim_frame_sequencer: directed ticks push hand-computed results,
// a monitor pops and compares on the cycle after each checked stimulus.
module tb_anim_frame_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic [5:0] hold_len = 6'd1;
  logic [1:0] mode = 2'b00;
  logic       pause = 1'b0;
  logic       step = 1'b0;
  logic       restart = 1'b0;
  logic [1:0] frame_num;
  logic       frame_change;
  logic       done;
  logic       dir_rev;

  anim_frame_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .frame_tick   (frame_tick),
    .hold_len     (hold_len),
    .mode         (mode),
    .pause        (pause),
    .step         (step),
    .restart      (restart),
    .frame_num    (frame_num),
    .frame_change (frame_change),
    .done         (done),
    .dir_rev      (dir_rev)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    f;
    logic  d;
    logic  r;
    logic  c;
    string nm;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   prev_f  = 0;
  logic issued  = 1'b0;
  logic due     = 1'b0;

  always @(posedge clk) due <= issued;

  always @(negedge clk) begin
    if (due) begin
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_underflow: output presented with no expected entry");
      end else begin
        exp_t e;
        e = q.pop_front();
        if (int'(frame_num) != e.f || done !== e.d || dir_rev !== e.r || frame_change !== e.c) begin
          n_fail++;
          $display("FAIL %s: got frame=%0d done=%0b dir=%0b chg=%0b, want frame=%0d done=%0b dir=%0b chg=%0b",
                   e.nm, frame_num, done, dir_rev, frame_change, e.f, e.d, e.r, e.c);
        end
      end
    end
  end

  // One clock of stimulus; when chk is set the expected post-edge outputs go to the scoreboard.
  task automatic drive(input logic tk, input logic rs, input logic st, input bit chk,
                       input int ef, input logic ed, input logic er, input string nm);
    exp_t e;
    frame_tick = tk;
    restart    = rs;
    step       = st;
    if (chk) begin
      e.f = ef; e.d = ed; e.r = er; e.c = (ef != prev_f); e.nm = nm;
      q.push_back(e);
      prev_f = ef;
    end
    issued = chk;
    @(posedge clk);
    @(negedge clk);
    frame_tick = 1'b0;
    restart    = 1'b0;
    step       = 1'b0;
    issued     = 1'b0;
  endtask

  task automatic tick_chk(input int ef, input logic ed, input logic er, input string nm);
    drive(1'b1, 1'b0, 1'b0, 1'b1, ef, ed, er, nm);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, "");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, "");
  endtask

  int fwd_seq[16]  = '{0,0,1,1,1,2,2,2,3,3,3,0,0,0,1,1};
  int pp_seq[8]    = '{1,2,3,2,1,0,1,2};
  int pp_dir[8]    = '{0,0,0,1,1,1,0,0};
  int os_seq[6]    = '{1,2,3,3,3,3};
  int os_done[6]   = '{0,0,0,1,1,1};

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_tests++;
    if (frame_num !== 2'd0 || done !== 1'b0 || dir_rev !== 1'b0 || frame_change !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got frame=%0d done=%0b dir=%0b chg=%0b, want all 0",
               frame_num, done, dir_rev, frame_change);
    end

    mode = 2'b00; hold_len = 6'd3;
    for (int i = 0; i < 16; i++) tick_chk(fwd_seq[i], 1'b0, 1'b0, $sformatf("fwd_hold3_t%0d", i + 1));

    mode = 2'b10; hold_len = 6'd1;
    drive(1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b0, "pp_restart");
    for (int i = 0; i < 8; i++) tick_chk(pp_seq[i], 1'b0, pp_dir[i][0], $sformatf("pingpong_t%0d", i + 1));

    mode = 2'b11; hold_len = 6'd0;
    drive(1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b0, "os_restart");
    for (int i = 0; i < 6; i++) tick_chk(os_seq[i], os_done[i][0], 1'b0, $sformatf("oneshot_t%0d", i + 1));
    drive(1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b0, "oneshot_restart");

    mode = 2'b00; hold_len = 6'd1;
    tick_chk(1, 1'b0, 1'b0, "pause_pre_t1");
    tick_chk(2, 1'b0, 1'b0, "pause_pre_t2");
    pause = 1'b1;
    tick_chk(2, 1'b0, 1'b0, "pause_enter");
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, "");
      idle(1);
    end
    tick_chk(3, 1'b0, 1'b0, "pause_step_collapse");
    for (int i = 0; i < 5; i++) tick_chk(3, 1'b0, 1'b0, $sformatf("pause_hold_t%0d", i + 1));
    drive(1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0, "pause_step_with_tick");
    idle(1);
    pause = 1'b0;
    tick_chk(0, 1'b0, 1'b0, "unpause_no_advance");
    tick_chk(1, 1'b0, 1'b0, "unpause_resume");
    drive(1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, "");
    tick_chk(2, 1'b0, 1'b0, "run_step_ignored");

    mode = 2'b01; hold_len = 6'd3;
    drive(1'b1, 1'b1, 1'b0, 1'b1, 3, 1'b0, 1'b0, "rev_restart_with_tick");
    tick_chk(3, 1'b0, 1'b0, "rev_hold_t1");
    tick_chk(3, 1'b0, 1'b0, "rev_hold_t2");
    tick_chk(2, 1'b0, 1'b0, "rev_hold_t3");
    tick_chk(2, 1'b0, 1'b0, "rev_hold_t4");

    #2 reset = 1'b1;
    #1;
    n_tests++;
    if (frame_num !== 2'd0 || done !== 1'b0 || dir_rev !== 1'b0 || frame_change !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_mid_hold: got frame=%0d done=%0b dir=%0b chg=%0b, want all 0",
               frame_num, done, dir_rev, frame_change);
    end
    @(negedge clk);
    reset = 1'b0;
    prev_f = 0;
    @(negedge clk);

    mode = 2'b00; hold_len = 6'd10;
    for (int i = 0; i < 5; i++) tick_chk(0, 1'b0, 1'b0, $sformatf("hold10_t%0d", i + 1));
    hold_len = 6'd2;
    tick_chk(1, 1'b0, 1'b0, "hold_shrink_advance");
    tick_chk(1, 1'b0, 1'b0, "hold_shrink_count");
    tick_chk(2, 1'b0, 1'b0, "hold_shrink_next");

    idle(3);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
